// File: rtl/prog_loader.sv
// Streaming program loader: consumes a framed byte stream (length, payload, XOR checksum)
// and writes the payload to program RAM from address 0, holding the CPU in reset meanwhile.
module prog_loader #(
  parameter int unsigned n    = 8,
  parameter int unsigned pc_n = 6
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            Start,
  input  logic [n-1:0]    InData,
  input  logic            InValid,
  output logic            InReady,
  output logic            WrEn,
  output logic [pc_n-1:0] WrAddr,
  output logic [n-1:0]    WrData,
  output logic            CpuHold,
  output logic            Done,
  output logic            Error
);

  localparam int unsigned RemW  = pc_n + 1;
  localparam int unsigned Depth = 1 << pc_n;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e            state;
  logic [pc_n-1:0]   addr;
  logic [RemW-1:0]   remaining;
  logic [n-1:0]      chksum;
  logic              xfer;
  logic              len_ok;

  assign xfer   = InValid && InReady;
  assign len_ok = (InData != '0) && (32'(InData) <= Depth);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= StIdle;
      InReady   <= 1'b0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      CpuHold   <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      chksum    <= '0;
    end else begin
      WrEn <= 1'b0;
      case (state)
        StIdle, StDone, StErr: begin
          if (Start) begin
            state   <= StLen;
            InReady <= 1'b1;
            CpuHold <= 1'b1;
            Done    <= 1'b0;
            Error   <= 1'b0;
            addr    <= '0;
            chksum  <= '0;
          end
        end
        StLen: begin
          if (xfer) begin
            if (len_ok) begin
              remaining <= RemW'(InData);
              state     <= StData;
            end else begin
              state   <= StErr;
              InReady <= 1'b0;
              Error   <= 1'b1;
            end
          end
        end
        StData: begin
          if (xfer) begin
            WrEn      <= 1'b1;
            WrAddr    <= addr;
            WrData    <= InData;
            chksum    <= chksum ^ InData;
            // Wraps to 0 after a full-depth frame; no write follows.
            addr      <= addr + pc_n'(1);
            remaining <= remaining - RemW'(1);
            if (remaining == RemW'(1)) begin
              state <= StChk;
            end
          end
        end
        StChk: begin
          if (xfer) begin
            InReady <= 1'b0;
            if (InData == chksum) begin
              state   <= StDone;
              Done    <= 1'b1;
              CpuHold <= 1'b0;
            end else begin
              state <= StErr;
              Error <= 1'b1;
            end
          end
        end
        default: begin
          state   <= StIdle;
          InReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random frames compared against a frame-level model
// (expected writes list, length bounds and XOR of payload).
module tb_prog_loader;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       Start;
  logic [7:0] InData;
  logic       InValid;
  logic       InReady;
  logic       WrEn;
  logic [5:0] WrAddr;
  logic [7:0] WrData;
  logic       CpuHold;
  logic       Done;
  logic       Error;

  int total = 0;
  int bad   = 0;

  logic [5:0] got_addr[$];
  logic [7:0] got_data[$];
  logic [7:0] pay[$];

  prog_loader #(.n(8), .pc_n(6)) dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Start   (Start),
    .InData  (InData),
    .InValid (InValid),
    .InReady (InReady),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .CpuHold (CpuHold),
    .Done    (Done),
    .Error   (Error)
  );

  always #5 Clock = ~Clock;

  // WrEn lasts one full cycle, so one sample per falling edge counts each write once.
  always @(negedge Clock) begin
    if (nReset && WrEn) begin
      got_addr.push_back(WrAddr);
      got_data.push_back(WrData);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    bit sent = 1'b0;
    int guard = 0;
    while (!sent && guard < 60) begin
      @(negedge Clock);
      if (int'($urandom_range(99, 0)) < stall_pct) begin
        InValid = 1'b0;
      end else begin
        InValid = 1'b1;
        InData  = b;
        sent    = InReady;
      end
      guard++;
    end
    if (!sent) check("send_timeout", {31'd0, sent}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    InValid = 1'b0;
    Start   = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] len, input logic [7:0] p[$],
                           input logic [7:0] chk, input int stall, input int start_at);
    bit         len_ok;
    bit         exp_done;
    logic [7:0] x;
    int         nexp;
    len_ok = (len != 8'd0) && (int'(len) <= 64);
    got_addr.delete();
    got_data.delete();
    pulse_start();
    check({tag, "_start_hold"}, {31'd0, CpuHold}, 32'd1);
    check({tag, "_start_done"}, {31'd0, Done}, 32'd0);
    check({tag, "_start_err"}, {31'd0, Error}, 32'd0);
    check({tag, "_start_rdy"}, {31'd0, InReady}, 32'd1);
    send_byte(len, stall);
    if (len_ok) begin
      foreach (p[i]) begin
        if (i == start_at) pulse_start();
        send_byte(p[i], stall);
      end
      send_byte(chk, stall);
    end
    @(negedge Clock);
    InValid = 1'b0;
    repeat (2) @(negedge Clock);
    // Frame-level model
    x = 8'h00;
    foreach (p[i]) x ^= p[i];
    exp_done = len_ok && (x == chk);
    nexp = len_ok ? p.size() : 0;
    check({tag, "_nwrites"}, got_addr.size(), nexp);
    for (int i = 0; i < got_addr.size() && i < nexp; i++) begin
      check({tag, "_addr"}, {26'd0, got_addr[i]}, i);
      check({tag, "_data"}, {24'd0, got_data[i]}, {24'd0, p[i]});
    end
    check({tag, "_done"}, {31'd0, Done}, {31'd0, exp_done});
    check({tag, "_err"}, {31'd0, Error}, {31'd0, !exp_done});
    check({tag, "_hold"}, {31'd0, CpuHold}, {31'd0, !exp_done});
    check({tag, "_rdy"}, {31'd0, InReady}, 32'd0);
    check({tag, "_wren_idle"}, {31'd0, WrEn}, 32'd0);
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] p[$]);
    logic [7:0] r = 8'h00;
    foreach (p[i]) r ^= p[i];
    return r;
  endfunction

  initial begin
    logic [7:0] len;
    logic [7:0] chk;
    nReset  = 1'b0;
    Start   = 1'b0;
    InValid = 1'b0;
    InData  = 8'h00;
    #3;
    check("rst_rdy", {31'd0, InReady}, 32'd0);
    check("rst_wren", {31'd0, WrEn}, 32'd0);
    check("rst_hold", {31'd0, CpuHold}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_err", {31'd0, Error}, 32'd0);
    check("rst_addr", {26'd0, WrAddr}, 32'd0);
    check("rst_data", {24'd0, WrData}, 32'd0);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    check("idle_rdy", {31'd0, InReady}, 32'd0);

    // Nominal frame
    pay.delete();
    pay.push_back(8'hA1); pay.push_back(8'hB2); pay.push_back(8'hC3);
    run_frame("nominal", 8'h03, pay, 8'hD0, 0, -1);

    // Start from DONE begins a new frame; this one has a bad checksum
    pay.delete();
    pay.push_back(8'h11); pay.push_back(8'h22);
    run_frame("badchk", 8'h02, pay, 8'h00, 0, -1);

    // Length bounds
    pay.delete();
    run_frame("len0", 8'h00, pay, 8'h00, 0, -1);
    run_frame("len65", 8'h41, pay, 8'h00, 0, -1);
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'($urandom()));
    run_frame("len64", 8'h40, pay, xor_all(pay), 0, -1);

    // Random frames with handshake stalls, some with corrupted checksum
    for (int f = 0; f < 5; f++) begin
      len = 8'($urandom_range(64, 1));
      pay.delete();
      for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom()));
      chk = xor_all(pay);
      if ($urandom_range(1, 0) == 1) chk ^= 8'($urandom_range(255, 1));
      run_frame("rand", len, pay, chk, 50, -1);
    end

    // Start pulsed mid-frame is ignored
    pay.delete();
    pay.push_back(8'h5A); pay.push_back(8'h0F); pay.push_back(8'h33);
    run_frame("midstart", 8'h03, pay, xor_all(pay), 30, 1);

    // Async reset while writes are in flight
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(posedge Clock);
    #2;
    check("pre_rst_wren", {31'd0, WrEn}, 32'd1);
    nReset = 1'b0;
    #1;
    check("arst_rdy", {31'd0, InReady}, 32'd0);
    check("arst_wren", {31'd0, WrEn}, 32'd0);
    check("arst_hold", {31'd0, CpuHold}, 32'd0);
    check("arst_done", {31'd0, Done}, 32'd0);
    check("arst_err", {31'd0, Error}, 32'd0);
    @(negedge Clock);
    InValid = 1'b0;
    nReset  = 1'b1;
    repeat (2) @(negedge Clock);
    check("post_rst_rdy", {31'd0, InReady}, 32'd0);
    check("post_rst_hold", {31'd0, CpuHold}, 32'd0);

    // Recovery from IDLE after reset
    pay.delete();
    pay.push_back(8'hFF);
    run_frame("after_rst", 8'h01, pay, 8'hFF, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Streaming program loader: the writing end of the program-memory interface the CPU core reads from.
- Accepts a framed byte stream (length, payload, XOR checksum) over a valid/ready handshake from a host source (UART receiver or switch-entry front end).
- Writes the payload to consecutive program RAM addresses starting at 0.
- Holds the CPU in reset while loading.
- Reports Done or Error when the frame ends.

Parameters:
n, 8, data/instruction word width (bits); payload bytes are n bits.
pc_n, 6, program address width; RAM depth 2**pc_n words.

Ports:
Clock  input  1  system clock, all state updates on rising edge.
nReset  input  1  asynchronous active-low reset.
Start  input  1  single-cycle request to begin a load frame.
InData  input  n  stream byte from host.
InValid  input  1  InData valid.
InReady  output  1  loader can accept a byte this cycle.
WrEn  output  1  program RAM write strobe, one cycle per word.
WrAddr  output  pc_n  program RAM write address.
WrData  output  n  program RAM write data.
CpuHold  output  1  high = hold CPU core in reset (drives core nReset low externally).
Done  output  1  level; frame loaded and checksum matched.
Error  output  1  level; bad length or checksum mismatch.

Behaviour:
- Reset (async, nReset=0):
  - State = IDLE.
  - InReady, WrEn, CpuHold, Done and Error = 0.
  - WrAddr, WrData and the internal count/checksum registers = 0.
- Transfer: a byte is consumed on a rising edge where InValid && InReady. InReady is registered-state-derived only; it never depends combinationally on InValid.
- States: IDLE, LEN, DATA, CHK, DONE, ERR.
- IDLE:
  - InReady=0.
  - Start=1 -> LEN, CpuHold<=1, Done<=0, Error<=0, address counter<=0, checksum<=0.
- LEN:
  - InReady=1.
  - On transfer, the byte is length L (unsigned, n bits).
  - L==0 or L>2**pc_n -> ERR.
  - Otherwise remaining<=L, go to DATA.
- DATA:
  - InReady=1.
  - Each transfer writes one word: WrEn=1, WrAddr=current address and WrData=byte, all registered and visible the cycle after the transfer (1-cycle write latency).
  - On each transfer, checksum ^= byte, address += 1, remaining -= 1.
  - The transfer with remaining==1 -> CHK.
  - Back-to-back transfers are allowed every cycle, producing back-to-back WrEn pulses.
- CHK:
  - InReady=1.
  - On transfer, byte==checksum -> DONE; otherwise -> ERR.
  - No RAM write occurs.
- DONE:
  - InReady=0, Done=1, CpuHold=0 (the CPU restarts from address 0 under its own reset sequencing).
- ERR:
  - InReady=0, Error=1, CpuHold stays 1 so a partially loaded program never runs.
- DONE/ERR + Start -> LEN, with the same initialisation as IDLE+Start.
- Start while in LEN/DATA/CHK is ignored; the frame in progress continues.
- Width rules:
  - Address counter is pc_n bits. L==2**pc_n writes addresses 0..2**pc_n-1 exactly; the counter wraps to 0 after the last write, but no further write occurs.
  - Remaining counter is pc_n+1 bits.
- WrEn is never high in any state other than the cycle after a DATA transfer. WrAddr/WrData hold their last values when WrEn=0.
- Reset mid-frame: everything returns to reset values immediately (CpuHold=0). RAM contents already written are left as is.

Test Plan:
- Nominal: Start; stream 03, A1, B2, C3, checksum D0 (A1^B2^C3) -> WrEn pulses at addresses 0,1,2 with A1,B2,C3; Done=1, Error=0, CpuHold falls after the checksum transfer.
- Bad checksum: Start; 02, 11, 22, then 00 (expected 33) -> two writes, Error=1, Done=0, CpuHold stays 1.
- Length bounds, pc_n=6:
  - L=00 -> Error with no writes.
  - L=41 (65) -> Error with no writes.
  - L=40 (64) with 64 bytes and matching checksum -> writes to addresses 0..63, Done=1.
- Handshake stalls: InValid toggled 1,0,0,1,... during DATA -> writes occur only on transfer edges, each one cycle later; address sequence contiguous with no duplicate or skipped writes.
- Start ignored mid-frame: Start pulsed during DATA of a 3-byte frame -> frame completes normally with Done=1. Start pulsed in DONE -> new frame begins, Done clears, CpuHold=1.
- Async reset mid-DATA: nReset low between clock edges -> InReady, WrEn, CpuHold, Done and Error go to 0 without waiting for a clock; state IDLE after release.
